// File: rtl/alu_ctrl_stage.sv
// alu_ctrl_stage: registered ALU-control decoder at the ID/EX boundary.
// Converts ALUOp + funct into a 3-bit ALU select behind a valid/ready skid buffer.
//
// Ports:
//   clk          rising-edge clock
//   rst          synchronous active-high reset
//   flush        squash held and incoming entries
//   in_valid     ID presents an instruction
//   in_ready     stage can accept (no skid entry held)
//   alu_op[1:0]  main-decoder ALUOp (00 ld/st, 01 branch, 10 R-type, 11 reserved)
//   funct[5:0]   instruction[5:0]
//   out_valid    out_sel/out_illegal valid for EX
//   out_ready    EX accepts (low = stall)
//   out_sel[2:0] ALU select code
//   out_illegal  entry came from an unsupported alu_op/funct
//   illegal_cnt  saturating count of delivered illegal entries
//
// Option macro: ALU_CTRL_ILLEGAL_CNT_EN
//   defined   -> illegal_cnt counts delivered illegal entries, saturating at 8'hFF
//   undefined -> no counter, illegal_cnt tied to 8'h00

module alu_ctrl_stage (
    input  logic       clk,
    input  logic       rst,
    input  logic       flush,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [1:0] alu_op,
    input  logic [5:0] funct,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [2:0] out_sel,
    output logic       out_illegal,
    output logic [7:0] illegal_cnt
);

    localparam logic [2:0] SEL_AND = 3'b000;
    localparam logic [2:0] SEL_OR  = 3'b001;
    localparam logic [2:0] SEL_ADD = 3'b010;
    localparam logic [2:0] SEL_SUB = 3'b110;
    localparam logic [2:0] SEL_SLT = 3'b111;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;

    // Output register
    logic       r_out_valid;
    logic [2:0] r_out_sel;
    logic       r_out_illegal;

    // Skid entry
    logic       r_skid_valid;
    logic [2:0] r_skid_sel;
    logic       r_skid_illegal;

    // Decoded incoming entry
    logic [2:0] w_dec_sel;
    logic       w_dec_ill;

    logic       w_accept;
    logic       w_deliver;
    logic       w_out_free;

    // ------------------------------------------------------------------
    // Combinational decode
    // ------------------------------------------------------------------
    always_comb begin
        w_dec_sel = SEL_ADD;
        w_dec_ill = 1'b0;
        case (alu_op)
            2'b00: w_dec_sel = SEL_ADD;
            2'b01: w_dec_sel = SEL_SUB;
            2'b10: begin
                case (funct)
                    FN_ADD:  w_dec_sel = SEL_ADD;
                    FN_SUB:  w_dec_sel = SEL_SUB;
                    FN_AND:  w_dec_sel = SEL_AND;
                    FN_OR:   w_dec_sel = SEL_OR;
                    FN_SLT:  w_dec_sel = SEL_SLT;
                    default: begin
                        w_dec_sel = SEL_ADD;
                        w_dec_ill = 1'b1;
                    end
                endcase
            end
            default: begin
                w_dec_sel = SEL_ADD;
                w_dec_ill = 1'b1;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Handshake
    // ------------------------------------------------------------------
    // in_ready depends only on a register, so out_ready never reaches it
    // combinationally.
    assign in_ready   = !r_skid_valid;
    assign w_accept   = in_valid && in_ready && !flush;
    assign w_deliver  = r_out_valid && out_ready;
    assign w_out_free = !r_out_valid || out_ready;

    // ------------------------------------------------------------------
    // Output register and skid entry
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_valid    <= 1'b0;
            r_out_sel      <= SEL_AND;
            r_out_illegal  <= 1'b0;
            r_skid_valid   <= 1'b0;
            r_skid_sel     <= SEL_AND;
            r_skid_illegal <= 1'b0;
        end else if (flush) begin
            // Payloads are kept so out_sel/out_illegal hold their values.
            r_out_valid  <= 1'b0;
            r_skid_valid <= 1'b0;
        end else if (w_out_free) begin
            if (r_skid_valid) begin
                // Older skid entry goes first to keep FIFO order.
                r_out_valid   <= 1'b1;
                r_out_sel     <= r_skid_sel;
                r_out_illegal <= r_skid_illegal;
                r_skid_valid  <= w_accept;
                if (w_accept) begin
                    r_skid_sel     <= w_dec_sel;
                    r_skid_illegal <= w_dec_ill;
                end
            end else if (w_accept) begin
                r_out_valid   <= 1'b1;
                r_out_sel     <= w_dec_sel;
                r_out_illegal <= w_dec_ill;
            end else begin
                r_out_valid <= 1'b0;
            end
        end else if (w_accept) begin
            // Output stalled: park the new entry in the skid slot.
            r_skid_valid   <= 1'b1;
            r_skid_sel     <= w_dec_sel;
            r_skid_illegal <= w_dec_ill;
        end
    end

    assign out_valid   = r_out_valid;
    assign out_sel     = r_out_sel;
    assign out_illegal = r_out_illegal;

    // ------------------------------------------------------------------
    // Illegal-op counter
    // ------------------------------------------------------------------
`ifdef ALU_CTRL_ILLEGAL_CNT_EN
    logic [7:0] r_illegal_cnt;

    // A delivery in a flush cycle still completes, so it is counted;
    // flush itself never clears the count.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_illegal_cnt <= 8'h00;
        end else if (w_deliver && r_out_illegal
                     && (r_illegal_cnt != 8'hFF)) begin
            r_illegal_cnt <= r_illegal_cnt + 8'h01;
        end
    end

    assign illegal_cnt = r_illegal_cnt;
`else
    logic w_unused_deliver;
    assign w_unused_deliver = w_deliver;
    assign illegal_cnt      = 8'h00;
`endif

endmodule

// File: tb/tb_alu_ctrl_stage.sv
// tb_alu_ctrl_stage: self-checking bench for alu_ctrl_stage.
// Reference model is a 2-deep FIFO of decoded entries plus a counter.

module tb_alu_ctrl_stage;

    logic       clk;
    logic       rst;
    logic       flush;
    logic       in_valid;
    logic       in_ready;
    logic [1:0] alu_op;
    logic [5:0] funct;
    logic       out_valid;
    logic       out_ready;
    logic [2:0] out_sel;
    logic       out_illegal;
    logic [7:0] illegal_cnt;

    int checks;
    int failures;

`ifdef ALU_CTRL_ILLEGAL_CNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    // Model: queue of {illegal, sel}, capacity 2.
    logic [3:0] q[$];
    logic [3:0] m_last;
    int         m_cnt;

    alu_ctrl_stage dut (
        .clk        (clk),
        .rst        (rst),
        .flush      (flush),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .alu_op     (alu_op),
        .funct      (funct),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_sel    (out_sel),
        .out_illegal(out_illegal),
        .illegal_cnt(illegal_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [3:0] ref_decode(input logic [1:0] op,
                                              input logic [5:0] f);
        if (op == 2'd0) return 4'b0_010;
        if (op == 2'd1) return 4'b0_110;
        if (op == 2'd3) return 4'b1_010;
        if (f == 6'd32) return 4'b0_010;
        if (f == 6'd34) return 4'b0_110;
        if (f == 6'd36) return 4'b0_000;
        if (f == 6'd37) return 4'b0_001;
        if (f == 6'd42) return 4'b0_111;
        return 4'b1_010;
    endfunction

    // Drive one cycle of inputs, advance the model over the edge,
    // and return at the following negedge.
    task automatic step(input logic v, input logic [1:0] op,
                        input logic [5:0] f, input logic ordy,
                        input logic fl, input logic r);
        logic dlv;
        logic acc;
        logic [3:0] item;
        in_valid  = v;
        alu_op    = op;
        funct     = f;
        out_ready = ordy;
        flush     = fl;
        rst       = r;
        dlv  = (q.size() > 0) && ordy;
        acc  = v && (q.size() < 2) && !fl;
        item = ref_decode(op, f);
        @(posedge clk);
        if (r) begin
            q.delete();
            m_last = 4'b0;
            m_cnt  = 0;
        end else begin
            if (dlv) begin
                if (CNT_EN && q[0][3] && m_cnt < 255) m_cnt++;
                void'(q.pop_front());
            end
            if (fl) q.delete();
            else if (acc) q.push_back(item);
            if (q.size() > 0) m_last = q[0];
        end
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 2'd0, 6'd0, 1'b1, 1'b0, 1'b0);
    endtask

    task automatic test_reset;
        step(1'b0, 2'd0, 6'd0, 1'b0, 1'b0, 1'b1);
        step(1'b0, 2'd0, 6'd0, 1'b0, 1'b0, 1'b1);
        rst = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || out_sel !== 3'b000 || out_illegal !== 1'b0
            || in_ready !== 1'b1 || illegal_cnt !== 8'h00) begin
            failures++;
            $display("FAIL reset: v=%b sel=%b ill=%b rdy=%b cnt=%h want 0 000 0 1 00",
                     out_valid, out_sel, out_illegal, in_ready, illegal_cnt);
        end
    endtask

    task automatic test_decode_sweep;
        logic [1:0] ops[7];
        logic [5:0] fns[7];
        logic [2:0] exp[7];
        ops = '{2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd0, 2'd1};
        fns = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010,
                6'b010101, 6'b111000};
        exp = '{3'b010, 3'b110, 3'b000, 3'b001, 3'b111, 3'b010, 3'b110};
        for (int i = 0; i < 7; i++) begin
            step(1'b1, ops[i], fns[i], 1'b1, 1'b0, 1'b0);
            checks++;
            if (out_valid !== 1'b1 || out_sel !== exp[i] || out_illegal !== 1'b0) begin
                failures++;
                $display("FAIL decode[%0d]: v=%b sel=%b ill=%b want 1 %b 0",
                         i, out_valid, out_sel, out_illegal, exp[i]);
            end
        end
        idle(1);
        checks++;
        if (out_valid !== 1'b0 || out_sel !== 3'b110) begin
            failures++;
            $display("FAIL decode_drain: v=%b sel=%b want 0 110", out_valid, out_sel);
        end
    endtask

    task automatic test_illegal;
        int base;
        step(1'b0, 2'd0, 6'd0, 1'b1, 1'b0, 1'b1);
        rst = 1'b0;
        step(1'b1, 2'd2, 6'b000111, 1'b1, 1'b0, 1'b0);
        checks++;
        if (out_valid !== 1'b1 || out_sel !== 3'b010 || out_illegal !== 1'b1) begin
            failures++;
            $display("FAIL illegal_funct: v=%b sel=%b ill=%b want 1 010 1",
                     out_valid, out_sel, out_illegal);
        end
        step(1'b1, 2'd3, 6'b000000, 1'b1, 1'b0, 1'b0);
        checks++;
        if (out_valid !== 1'b1 || out_sel !== 3'b010 || out_illegal !== 1'b1) begin
            failures++;
            $display("FAIL illegal_op11: v=%b sel=%b ill=%b want 1 010 1",
                     out_valid, out_sel, out_illegal);
        end
        idle(1);
        base = CNT_EN ? 2 : 0;
        checks++;
        if (illegal_cnt !== 8'(base)) begin
            failures++;
            $display("FAIL illegal_cnt: got %0d want %0d", illegal_cnt, base);
        end
    endtask

    task automatic test_backpressure;
        step(1'b0, 2'd0, 6'd0, 1'b0, 1'b0, 1'b1);
        rst = 1'b0;
        // A=AND, B=OR, C=SLT with EX stalled
        step(1'b1, 2'd2, 6'b100100, 1'b0, 1'b0, 1'b0);
        checks++;
        if (out_valid !== 1'b1 || out_sel !== 3'b000 || in_ready !== 1'b1) begin
            failures++;
            $display("FAIL bp_A: v=%b sel=%b rdy=%b want 1 000 1", out_valid, out_sel, in_ready);
        end
        step(1'b1, 2'd2, 6'b100101, 1'b0, 1'b0, 1'b0);
        checks++;
        if (out_valid !== 1'b1 || out_sel !== 3'b000 || in_ready !== 1'b0) begin
            failures++;
            $display("FAIL bp_B: v=%b sel=%b rdy=%b want 1 000 0", out_valid, out_sel, in_ready);
        end
        step(1'b1, 2'd2, 6'b101010, 1'b0, 1'b0, 1'b0);
        checks++;
        if (out_valid !== 1'b1 || out_sel !== 3'b000 || in_ready !== 1'b0) begin
            failures++;
            $display("FAIL bp_C_blocked: v=%b sel=%b rdy=%b want 1 000 0",
                     out_valid, out_sel, in_ready);
        end
        // Release; C stays presented until accepted.
        step(1'b1, 2'd2, 6'b101010, 1'b1, 1'b0, 1'b0);
        checks++;
        if (out_valid !== 1'b1 || out_sel !== 3'b001 || in_ready !== 1'b1) begin
            failures++;
            $display("FAIL bp_rel_B: v=%b sel=%b rdy=%b want 1 001 1",
                     out_valid, out_sel, in_ready);
        end
        step(1'b1, 2'd2, 6'b101010, 1'b1, 1'b0, 1'b0);
        checks++;
        if (out_valid !== 1'b1 || out_sel !== 3'b111) begin
            failures++;
            $display("FAIL bp_rel_C: v=%b sel=%b want 1 111", out_valid, out_sel);
        end
        idle(1);
        checks++;
        if (out_valid !== 1'b0 || out_sel !== 3'b111) begin
            failures++;
            $display("FAIL bp_drain: v=%b sel=%b want 0 111", out_valid, out_sel);
        end
    endtask

    task automatic test_flush;
        step(1'b1, 2'd2, 6'b100100, 1'b0, 1'b0, 1'b0);
        step(1'b1, 2'd2, 6'b100101, 1'b0, 1'b0, 1'b0);
        checks++;
        if (in_ready !== 1'b0) begin
            failures++;
            $display("FAIL flush_fill: rdy=%b want 0", in_ready);
        end
        step(1'b1, 2'd2, 6'b101010, 1'b0, 1'b1, 1'b0);
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_sel !== 3'b000) begin
            failures++;
            $display("FAIL flush: v=%b rdy=%b sel=%b want 0 1 000",
                     out_valid, in_ready, out_sel);
        end
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 2'd0, 6'd0, 1'b1, 1'b0, 1'b0);
            checks++;
            if (out_valid !== 1'b0) begin
                failures++;
                $display("FAIL flush_ghost[%0d]: v=%b want 0", i, out_valid);
            end
        end
    endtask

    task automatic test_reset_mid_stall;
        step(1'b1, 2'd3, 6'd0, 1'b1, 1'b0, 1'b0);
        step(1'b1, 2'd2, 6'b000001, 1'b0, 1'b0, 1'b0);
        step(1'b1, 2'd2, 6'b100010, 1'b0, 1'b0, 1'b0);
        step(1'b1, 2'd1, 6'd0, 1'b0, 1'b0, 1'b1);
        rst = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || out_sel !== 3'b000 || in_ready !== 1'b1
            || illegal_cnt !== 8'h00 || out_illegal !== 1'b0) begin
            failures++;
            $display("FAIL rst_stall: v=%b sel=%b rdy=%b cnt=%h ill=%b want 0 000 1 00 0",
                     out_valid, out_sel, in_ready, illegal_cnt, out_illegal);
        end
    endtask

    task automatic test_random;
        logic v, o, fl;
        logic [1:0] op;
        logic [5:0] f;
        logic [5:0] legal[5];
        int bad;
        legal = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};
        bad = 0;
        for (int i = 0; i < 600; i++) begin
            v  = ($urandom_range(3) != 0);
            o  = ($urandom_range(2) != 0);
            fl = ($urandom_range(24) == 0);
            op = 2'($urandom_range(3));
            f  = ($urandom_range(1) == 0) ? legal[$urandom_range(4)]
                                          : 6'($urandom);
            step(v, op, f, o, fl, 1'b0);
            checks++;
            if (out_valid !== (q.size() > 0) || in_ready !== (q.size() < 2)
                || out_sel !== m_last[2:0] || out_illegal !== m_last[3]
                || illegal_cnt !== 8'(m_cnt)) begin
                failures++;
                bad++;
                if (bad < 10)
                    $display("FAIL random[%0d]: v=%b rdy=%b sel=%b ill=%b cnt=%0d want %b %b %b %b %0d",
                             i, out_valid, in_ready, out_sel, out_illegal, illegal_cnt,
                             q.size() > 0, q.size() < 2, m_last[2:0], m_last[3], m_cnt);
            end
        end
    endtask

    task automatic test_saturation;
        step(1'b0, 2'd0, 6'd0, 1'b1, 1'b0, 1'b1);
        rst = 1'b0;
        for (int i = 0; i < 260; i++) step(1'b1, 2'd3, 6'd0, 1'b1, 1'b0, 1'b0);
        idle(1);
        checks++;
        if (illegal_cnt !== (CNT_EN ? 8'hFF : 8'h00)) begin
            failures++;
            $display("FAIL sat: cnt=%h want %h", illegal_cnt, CNT_EN ? 8'hFF : 8'h00);
        end
        for (int i = 0; i < 5; i++) step(1'b1, 2'd2, 6'd5, 1'b1, 1'b0, 1'b0);
        idle(1);
        step(1'b1, 2'd2, 6'd0, 1'b0, 1'b1, 1'b0);
        checks++;
        if (illegal_cnt !== (CNT_EN ? 8'hFF : 8'h00)) begin
            failures++;
            $display("FAIL sat_hold: cnt=%h want %h", illegal_cnt, CNT_EN ? 8'hFF : 8'h00);
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        m_last   = 4'b0;
        m_cnt    = 0;
        rst      = 1'b1;
        flush    = 1'b0;
        in_valid = 1'b0;
        alu_op   = 2'd0;
        funct    = 6'd0;
        out_ready = 1'b0;
        @(negedge clk);
        test_reset();
        test_decode_sweep();
        test_illegal();
        test_backpressure();
        test_flush();
        test_reset_mid_stall();
        test_random();
        test_saturation();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
